// File: rtl/knight_pkg.sv
// Shared types, move table and board-index helper for the knight's-tour engine.
package knight_pkg;

  typedef enum logic [2:0] {IDLE, PLACE, PROBE, BACKTRACK, PAUSE, DONE} state_t;
  typedef enum logic {NO, YES} boolean;

  localparam int unsigned CW     = 4;  // coordinate width
  localparam int unsigned IW     = 3;  // move index width
  localparam int unsigned AW     = 8;  // flat cell index width (up to 15x15)
  localparam int unsigned NMOVES = 8;

  // Move order (drow, dcol): (2,1) (1,2) (-1,2) (-2,1) (-2,-1) (-1,-2) (1,-2) (2,-1)
  localparam logic signed [4:0] MOVE_DR [NMOVES] =
    '{5'sd2, 5'sd1, -5'sd1, -5'sd2, -5'sd2, -5'sd1, 5'sd1, 5'sd2};
  localparam logic signed [4:0] MOVE_DC [NMOVES] =
    '{5'sd1, 5'sd2, 5'sd2, 5'sd1, -5'sd1, -5'sd2, -5'sd2, -5'sd1};

  typedef struct packed {
    logic [IW-1:0] i;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } frame_t;

  function automatic logic [AW-1:0] cell_idx(input logic [CW-1:0] x,
                                             input logic [CW-1:0] y,
                                             input int unsigned   cols);
    return AW'(32'(x) * cols + 32'(y));
  endfunction

endpackage

// File: rtl/knight_tour_engine_if.sv
// Control, status and board read port of the knight's-tour engine.
interface knight_tour_engine_if #(
  parameter int unsigned DW = 5
);
  logic          start;
  logic [3:0]    start_x;
  logic [3:0]    start_y;
  logic          step_mode;
  logic          step;
  logic          abort;
  logic          busy;
  logic          done;
  logic          found;
  logic [DW-1:0] depth;
  logic          ev_next;
  logic          ev_back;
  logic [3:0]    rd_x;
  logic [3:0]    rd_y;
  logic [DW-1:0] rd_data;

  modport master (
    output start, start_x, start_y, step_mode, step, abort, rd_x, rd_y,
    input  busy, done, found, depth, ev_next, ev_back, rd_data
  );

  modport slave (
    input  start, start_x, start_y, step_mode, step, abort, rd_x, rd_y,
    output busy, done, found, depth, ev_next, ev_back, rd_data
  );
endinterface

// File: rtl/knight_move_gen.sv
// Combinational candidate generator: applies move i to (x,y) and reports legality.
module knight_move_gen
  import knight_pkg::*;
#(
  parameter int unsigned ROWS = 5,
  parameter int unsigned COLS = 5
) (
  input  logic [CW-1:0]        x,
  input  logic [CW-1:0]        y,
  input  logic [IW-1:0]        i,
  input  logic [ROWS*COLS-1:0] occ,
  output logic [CW-1:0]        nx,
  output logic [CW-1:0]        ny,
  output logic                 legal
);
  localparam int unsigned CELLS = ROWS * COLS;

  logic signed [4:0] sx;
  logic signed [4:0] sy;
  logic              in_range;
  logic              hit;
  logic [AW-1:0]     idx;

  // A set bit 4 means the signed sum went negative or past 15.
  always_comb begin
    sx       = $signed({1'b0, x}) + MOVE_DR[i];
    sy       = $signed({1'b0, y}) + MOVE_DC[i];
    nx       = sx[3:0];
    ny       = sy[3:0];
    in_range = !sx[4] && !sy[4] && (32'(nx) < ROWS) && (32'(ny) < COLS);
    idx      = cell_idx(nx, ny, COLS);
    hit      = 1'b0;
    for (int unsigned k = 0; k < CELLS; k++) begin
      if (idx == AW'(k)) hit = occ[k];
    end
    legal = in_range && !hit;
  end

endmodule

// File: rtl/knight_tour_engine.sv
// Depth-first knight's-tour solver with explicit move stack, single-step and abort.
module knight_tour_engine
  import knight_pkg::*;
#(
  parameter int unsigned ROWS = 5,
  parameter int unsigned COLS = 5
) (
  input  logic                clk,
  input  logic                rst,
  knight_tour_engine_if.slave bus
);
  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned DW    = $clog2(CELLS + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [IW-1:0] i_q, i_d;
  logic [DW-1:0] depth_q, depth_d, depth_inc;
  boolean        found_q, found_d;
  logic          busy_q, done_q, done_d;
  logic          ev_next_q, ev_next_d, ev_back_q, ev_back_d;

  logic [DW-1:0]    board [CELLS];
  frame_t           stack [CELLS];
  logic [CELLS-1:0] occ;
  logic             clr_all, wr_en, push;
  logic [AW-1:0]    wr_idx, cur_idx, mv_idx;
  logic [DW-1:0]    wr_val, rd_val;
  frame_t           pop_frame;
  logic [CW-1:0]    mv_nx, mv_ny;
  logic             mv_legal, start_ok;

  knight_move_gen #(.ROWS(ROWS), .COLS(COLS)) u_move_gen (
    .x     (x_q),
    .y     (y_q),
    .i     (i_q),
    .occ   (occ),
    .nx    (mv_nx),
    .ny    (mv_ny),
    .legal (mv_legal)
  );

  assign depth_inc = depth_q + DW'(1);
  assign cur_idx   = cell_idx(x_q, y_q, COLS);
  assign mv_idx    = cell_idx(mv_nx, mv_ny, COLS);
  assign start_ok  = (32'(bus.start_x) < ROWS) && (32'(bus.start_y) < COLS);

  // Occupancy view and top-of-stack read; stack slot n holds the frame pushed at depth n.
  always_comb begin
    occ       = '0;
    pop_frame = '0;
    for (int unsigned k = 0; k < CELLS; k++) begin
      occ[k] = (board[k] != '0);
      if (DW'(k) == depth_q - DW'(1)) pop_frame = stack[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    i_d       = i_q;
    depth_d   = depth_q;
    found_d   = found_q;
    done_d    = 1'b0;
    ev_next_d = 1'b0;
    ev_back_d = 1'b0;
    clr_all   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = cur_idx;
    wr_val    = '0;
    push      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          found_d = NO;
          if (start_ok) begin
            clr_all = 1'b1;
            x_d     = bus.start_x;
            y_d     = bus.start_y;
            depth_d = '0;
            state_d = PLACE;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      PLACE: begin
        wr_en   = 1'b1;
        wr_val  = DW'(1);
        depth_d = DW'(1);
        i_d     = '0;
        if (CELLS == 1) begin
          state_d = DONE;
          found_d = YES;
          done_d  = 1'b1;
        end else begin
          state_d = PROBE;
        end
      end
      PROBE: begin
        if (mv_legal) begin
          push      = 1'b1;
          x_d       = mv_nx;
          y_d       = mv_ny;
          wr_en     = 1'b1;
          wr_idx    = mv_idx;
          wr_val    = depth_inc;
          depth_d   = depth_inc;
          i_d       = '0;
          ev_next_d = 1'b1;
          if (depth_inc == DW'(CELLS)) begin
            state_d = DONE;
            found_d = YES;
            done_d  = 1'b1;
          end else if (bus.step_mode) begin
            state_d = PAUSE;
          end
        end else if (i_q != IW'(7)) begin
          i_d = i_q + IW'(1);
        end else begin
          state_d = BACKTRACK;
        end
      end
      BACKTRACK: begin
        if (depth_q == DW'(1)) begin
          state_d = DONE;
          found_d = NO;
          done_d  = 1'b1;
        end else begin
          wr_en     = 1'b1;
          x_d       = pop_frame.x;
          y_d       = pop_frame.y;
          depth_d   = depth_q - DW'(1);
          ev_back_d = 1'b1;
          if (pop_frame.i != IW'(7)) begin
            i_d     = pop_frame.i + IW'(1);
            state_d = bus.step_mode ? PAUSE : PROBE;
          end
        end
      end
      PAUSE: begin
        if (bus.step || !bus.step_mode) state_d = PROBE;
      end
      default: state_d = IDLE;
    endcase

    // Abort freezes the board and position exactly as they are.
    if (bus.abort && (state_q inside {PLACE, PROBE, BACKTRACK, PAUSE})) begin
      state_d   = DONE;
      x_d       = x_q;
      y_d       = y_q;
      i_d       = i_q;
      depth_d   = depth_q;
      found_d   = NO;
      done_d    = 1'b1;
      ev_next_d = 1'b0;
      ev_back_d = 1'b0;
      clr_all   = 1'b0;
      wr_en     = 1'b0;
      push      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      i_q       <= '0;
      depth_q   <= '0;
      found_q   <= NO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ev_next_q <= 1'b0;
      ev_back_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      i_q       <= i_d;
      depth_q   <= depth_d;
      found_q   <= found_d;
      busy_q    <= state_d inside {PLACE, PROBE, BACKTRACK, PAUSE};
      done_q    <= done_d;
      ev_next_q <= ev_next_d;
      ev_back_q <= ev_back_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < CELLS; k++) begin
      if (rst || clr_all)                  board[k] <= '0;
      else if (wr_en && wr_idx == AW'(k))  board[k] <= wr_val;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < CELLS; k++) begin
      if (push && DW'(k) == depth_q) stack[k] <= '{i: i_q, x: x_q, y: y_q};
    end
  end

  always_comb begin
    rd_val = '0;
    if ((32'(bus.rd_x) < ROWS) && (32'(bus.rd_y) < COLS)) begin
      for (int unsigned k = 0; k < CELLS; k++) begin
        if (cell_idx(bus.rd_x, bus.rd_y, COLS) == AW'(k)) rd_val = board[k];
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.found   = (found_q == YES);
  assign bus.depth   = depth_q;
  assign bus.ev_next = ev_next_q;
  assign bus.ev_back = ev_back_q;
  assign bus.rd_data = rd_val;

endmodule

// File: tb/tb_knight_tour_engine.sv
// Directed bench for knight_tour_engine on 5x5, 3x3, 4x4 and 1x1 boards.
module tb_knight_tour_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  knight_tour_engine_if #(.DW(5)) b55 ();
  knight_tour_engine_if #(.DW(4)) b33 ();
  knight_tour_engine_if #(.DW(5)) b44 ();
  knight_tour_engine_if #(.DW(1)) b11 ();

  knight_tour_engine #(.ROWS(5), .COLS(5)) u55 (.clk(clk), .rst(rst), .bus(b55));
  knight_tour_engine #(.ROWS(3), .COLS(3)) u33 (.clk(clk), .rst(rst), .bus(b33));
  knight_tour_engine #(.ROWS(4), .COLS(4)) u44 (.clk(clk), .rst(rst), .bus(b44));
  knight_tour_engine #(.ROWS(1), .COLS(1)) u11 (.clk(clk), .rst(rst), .bus(b11));

  typedef struct {
    int         brd;
    logic [3:0] rx;
    logic [3:0] ry;
    int         exp;
  } rd_vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic rd55(input int r, input int c, output int v);
    b55.rd_x = 4'(r);
    b55.rd_y = 4'(c);
    #1;
    v = int'(b55.rd_data);
  endtask

  task automatic nonzero55(output int n);
    int v;
    n = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        rd55(r, c, v);
        if (v != 0) n++;
      end
  endtask

  task automatic pulse_start55(input int sx, input int sy);
    b55.start_x = 4'(sx);
    b55.start_y = 4'(sy);
    b55.start   = 1'b1;
    @(negedge clk);
    b55.start   = 1'b0;
  endtask

  task automatic wait_ev_next55(input string name, input int limit);
    int n = 0;
    while (!b55.ev_next && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(b55.ev_next), 1);
  endtask

  rd_vec_t vecs[$];
  int v, n, d0, bad, got33, got44, f33, f44, d33, d44;
  int cnt [26];
  int pr  [26];
  int pc  [26];
  int dr, dc;

  initial begin
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        if (r < 3 && c < 3) vecs.push_back('{33, 4'(r), 4'(c), (r == 0 && c == 0) ? 1 : 0});
        if (r < 4 && c < 4) vecs.push_back('{44, 4'(r), 4'(c), (r == 0 && c == 0) ? 1 : 0});
      end
    vecs.push_back('{33, 4'd3,  4'd0,  0});
    vecs.push_back('{33, 4'd0,  4'd15, 0});
    vecs.push_back('{44, 4'd4,  4'd4,  0});
    vecs.push_back('{44, 4'd15, 4'd0,  0});

    b55.start = 0; b55.start_x = 0; b55.start_y = 0; b55.step_mode = 0; b55.step = 0;
    b55.abort = 0; b55.rd_x = 0; b55.rd_y = 0;
    b33.start = 0; b33.start_x = 0; b33.start_y = 0; b33.step_mode = 0; b33.step = 0;
    b33.abort = 0; b33.rd_x = 0; b33.rd_y = 0;
    b44.start = 0; b44.start_x = 0; b44.start_y = 0; b44.step_mode = 0; b44.step = 0;
    b44.abort = 0; b44.rd_x = 0; b44.rd_y = 0;
    b11.start = 0; b11.start_x = 0; b11.start_y = 0; b11.step_mode = 0; b11.step = 0;
    b11.abort = 0; b11.rd_x = 0; b11.rd_y = 0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(b55.busy), 0);
    check("reset_done", int'(b55.done), 0);
    check("reset_found", int'(b55.found), 0);
    check("reset_depth", int'(b55.depth), 0);
    check("reset_ev", int'(b55.ev_next) + int'(b55.ev_back), 0);
    nonzero55(n);
    check("reset_cells", n, 0);

    // Small boards: 1x1 completes immediately, 3x3 and 4x4 exhaust.
    b11.start = 1; b33.start = 1; b44.start = 1;
    @(negedge clk);
    b11.start = 0; b33.start = 0; b44.start = 0;
    check("b11_done_early", int'(b11.done), 0);
    @(negedge clk);
    check("b11_done", int'(b11.done), 1);
    check("b11_found", int'(b11.found), 1);
    check("b11_depth", int'(b11.depth), 1);
    got33 = 0; got44 = 0; f33 = -1; f44 = -1; d33 = -1; d44 = -1;
    for (int k = 0; k < 1_000_000 && !(got33 == 1 && got44 == 1); k++) begin
      @(negedge clk);
      if (got33 == 0 && b33.done) begin got33 = 1; f33 = int'(b33.found); d33 = int'(b33.depth); end
      if (got44 == 0 && b44.done) begin got44 = 1; f44 = int'(b44.found); d44 = int'(b44.depth); end
    end
    check("b33_done", got33, 1);
    check("b33_found", f33, 0);
    check("b33_depth", d33, 1);
    check("b44_done", got44, 1);
    check("b44_found", f44, 0);
    check("b44_depth", d44, 1);
    foreach (vecs[k]) begin
      if (vecs[k].brd == 33) begin
        b33.rd_x = vecs[k].rx; b33.rd_y = vecs[k].ry; #1;
        check($sformatf("b33_cell_%0d_%0d", vecs[k].rx, vecs[k].ry), int'(b33.rd_data), vecs[k].exp);
      end else begin
        b44.rd_x = vecs[k].rx; b44.rd_y = vecs[k].ry; #1;
        check($sformatf("b44_cell_%0d_%0d", vecs[k].rx, vecs[k].ry), int'(b44.rd_data), vecs[k].exp);
      end
    end

    // Single-step mode on 5x5.
    @(negedge clk);
    b55.step_mode = 1;
    pulse_start55(0, 0);
    wait_ev_next55("step_first_ev", 20);
    check("step_depth2", int'(b55.depth), 2);
    rd55(2, 1, v);
    check("step_cell_2_1", v, 2);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!b55.busy || b55.depth != 5'd2 || b55.ev_next || b55.ev_back) bad++;
    end
    check("pause_hold", bad, 0);
    b55.step = 1;
    @(negedge clk);
    b55.step = 0;
    wait_ev_next55("step_second_ev", 20);
    check("step_depth3", int'(b55.depth), 3);
    rd55(4, 2, v);
    check("step_cell_4_2", v, 3);

    // Resume, then reset mid-search.
    b55.step_mode = 0;
    repeat (30) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_busy", int'(b55.busy), 0);
    check("rst_done", int'(b55.done), 0);
    check("rst_found", int'(b55.found), 0);
    check("rst_depth", int'(b55.depth), 0);
    check("rst_ev", int'(b55.ev_next) + int'(b55.ev_back), 0);
    nonzero55(n);
    check("rst_cells", n, 0);

    // Abort 50 cycles into a run.
    pulse_start55(0, 0);
    repeat (49) @(negedge clk);
    d0 = int'(b55.depth);
    b55.abort = 1;
    @(negedge clk);
    b55.abort = 0;
    check("abort_done", int'(b55.done), 1);
    check("abort_found", int'(b55.found), 0);
    check("abort_busy", int'(b55.busy), 0);
    check("abort_depth", int'(b55.depth), d0);
    rd55(0, 0, v);
    check("abort_start_cell", v, 1);
    repeat (3) @(negedge clk);
    check("abort_done_pulse", int'(b55.done), 0);
    check("abort_depth_hold", int'(b55.depth), d0);

    // Restart and run the full 5x5 tour, with a stray start while busy.
    pulse_start55(0, 0);
    nonzero55(n);
    check("restart_cleared", n, 0);
    @(negedge clk);
    check("restart_depth1", int'(b55.depth), 1);
    rd55(0, 0, v);
    check("restart_cell_0_0", v, 1);
    b55.rd_x = 4'd2; b55.rd_y = 4'd1;
    wait_ev_next55("tour_first_ev", 20);
    #1;
    check("tour_first_cell", int'(b55.rd_data), 2);
    repeat (10) @(negedge clk);
    pulse_start55(1, 1);
    check("busy_start_busy", int'(b55.busy), 1);
    rd55(0, 0, v);
    check("busy_start_ignored", v, 1);
    n = 0;
    while (!b55.done && n < 10_000_000) begin
      @(negedge clk);
      n++;
    end
    check("tour_done", int'(b55.done), 1);
    check("tour_found", int'(b55.found), 1);
    check("tour_depth", int'(b55.depth), 25);
    for (int k = 0; k < 26; k++) begin cnt[k] = 0; pr[k] = -9; pc[k] = -9; end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        rd55(r, c, v);
        if (v >= 1 && v <= 25) begin cnt[v]++; pr[v] = r; pc[v] = c; end
      end
    bad = 0;
    for (int k = 1; k <= 25; k++) if (cnt[k] != 1) bad++;
    check("tour_permutation", bad, 0);
    bad = 0;
    for (int k = 1; k < 25; k++) begin
      dr = (pr[k+1] > pr[k]) ? pr[k+1] - pr[k] : pr[k] - pr[k+1];
      dc = (pc[k+1] > pc[k]) ? pc[k+1] - pc[k] : pc[k] - pc[k+1];
      if (!((dr == 1 && dc == 2) || (dr == 2 && dc == 1))) bad++;
    end
    check("tour_knight_steps", bad, 0);
    rd55(0, 0, v);
    check("tour_start_cell", v, 1);

    // Out-of-range start from DONE leaves the board and depth alone.
    @(negedge clk);
    pulse_start55(7, 0);
    check("oor_done", int'(b55.done), 1);
    check("oor_found", int'(b55.found), 0);
    check("oor_busy", int'(b55.busy), 0);
    check("oor_depth", int'(b55.depth), 25);
    rd55(0, 0, v);
    check("oor_cell_0_0", v, 1);
    @(negedge clk);
    check("oor_done_pulse", int'(b55.done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
